ext_int_ctrl: RTL and testbench

EXT_INT_CTRL -- requirements
Module: ext_int_ctrl

---
 rtl/ext_int_ctrl.sv | 156 +++++++++++++++
 tb/tb_ext_int_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: INT0/INT1 edge/level sensing and Port D pin-change
// interrupt group 2, with I/O-space and data-memory-space register access.
module ext_int_ctrl #(
  parameter logic [5:0] PCIFR_Address  = 6'h1B,
  parameter logic [5:0] EIFR_Address   = 6'h1C,
  parameter logic [5:0] EIMSK_Address  = 6'h1D,
  parameter logic [7:0] PCICR_Address  = 8'h68,
  parameter logic [7:0] EICRA_Address  = 8'h69,
  parameter logic [7:0] PCMSK2_Address = 8'h6D
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  output logic [7:0] dm_dbus_out,
  output logic       dm_out_en,
  input  logic [7:0] pinD_i,
  output logic       INT0_EN,
  output logic       INT1_EN,
  output logic       PCIE2,
  output logic [7:0] PCINT,
  output logic       int0_irq,
  output logic       int1_irq,
  output logic       pcint2_irq,
  input  logic       int0_ack,
  input  logic       int1_ack,
  input  logic       pcint2_ack
);

  logic [7:0] s1_q, s2_q, s3_q;
  logic [1:0] eimsk_q, eimsk_d;
  logic [1:0] eifr_q, eifr_d;
  logic       pcif_q, pcif_d;
  logic       pcicr_q, pcicr_d;
  logic [3:0] eicra_q, eicra_d;
  logic [7:0] pcmsk2_q, pcmsk2_d;

  logic       wr_eimsk, wr_eifr, wr_pcifr, wr_pcicr, wr_eicra, wr_pcmsk2;
  logic       set_int0, set_int1, set_pc;
  logic       clr_int0, clr_int1, clr_pc;

  // Sense-control decode: 00 level (never latches), 01 any change, 10 falling, 11 rising.
  function automatic logic edge_hit(input logic [1:0] isc, input logic cur, input logic prev);
    logic hit;
    case (isc)
      2'b01:   hit = cur ^ prev;
      2'b10:   hit = ~cur & prev;
      2'b11:   hit = cur & ~prev;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign wr_eimsk  = iowe && (IO_Addr == EIMSK_Address);
  assign wr_eifr   = iowe && (IO_Addr == EIFR_Address);
  assign wr_pcifr  = iowe && (IO_Addr == PCIFR_Address);
  assign wr_pcicr  = ramwe && (ramadr == PCICR_Address);
  assign wr_eicra  = ramwe && (ramadr == EICRA_Address);
  assign wr_pcmsk2 = ramwe && (ramadr == PCMSK2_Address);

  assign set_int0 = edge_hit(eicra_q[1:0], s2_q[2], s3_q[2]);
  assign set_int1 = edge_hit(eicra_q[3:2], s2_q[3], s3_q[3]);
  assign set_pc   = |((s2_q ^ s3_q) & pcmsk2_q);

  assign clr_int0 = (wr_eifr && dbus_in[0]) || int0_ack;
  assign clr_int1 = (wr_eifr && dbus_in[1]) || int1_ack;
  assign clr_pc   = (wr_pcifr && dbus_in[2]) || pcint2_ack;

  always_comb begin
    eimsk_d  = wr_eimsk  ? dbus_in[1:0] : eimsk_q;
    pcicr_d  = wr_pcicr  ? dbus_in[2]   : pcicr_q;
    eicra_d  = wr_eicra  ? dbus_in[3:0] : eicra_q;
    pcmsk2_d = wr_pcmsk2 ? dbus_in      : pcmsk2_q;
    // A set in the same cycle as a clear wins so no edge is lost.
    eifr_d[0] = set_int0 | (eifr_q[0] & ~clr_int0);
    eifr_d[1] = set_int1 | (eifr_q[1] & ~clr_int1);
    pcif_d    = set_pc   | (pcif_q    & ~clr_pc);
  end

  // Reset loads the synchronizers with the live pins so release cannot fake an edge.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      s1_q     <= pinD_i;
      s2_q     <= pinD_i;
      s3_q     <= pinD_i;
      eimsk_q  <= '0;
      eifr_q   <= '0;
      pcif_q   <= 1'b0;
      pcicr_q  <= 1'b0;
      eicra_q  <= '0;
      pcmsk2_q <= '0;
    end else begin
      s1_q     <= pinD_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      eimsk_q  <= eimsk_d;
      eifr_q   <= eifr_d;
      pcif_q   <= pcif_d;
      pcicr_q  <= pcicr_d;
      eicra_q  <= eicra_d;
      pcmsk2_q <= pcmsk2_d;
    end
  end

  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (iore && !ireset) begin
      if (IO_Addr == EIMSK_Address) begin
        dbus_out = {6'b0, eimsk_q};
        out_en   = 1'b1;
      end else if (IO_Addr == EIFR_Address) begin
        dbus_out = {6'b0, eifr_q};
        out_en   = 1'b1;
      end else if (IO_Addr == PCIFR_Address) begin
        dbus_out = {5'b0, pcif_q, 2'b0};
        out_en   = 1'b1;
      end
    end
  end

  always_comb begin
    dm_dbus_out = 8'h00;
    dm_out_en   = 1'b0;
    if (ramre && !ireset) begin
      if (ramadr == PCICR_Address) begin
        dm_dbus_out = {5'b0, pcicr_q, 2'b0};
        dm_out_en   = 1'b1;
      end else if (ramadr == EICRA_Address) begin
        dm_dbus_out = {4'b0, eicra_q};
        dm_out_en   = 1'b1;
      end else if (ramadr == PCMSK2_Address) begin
        dm_dbus_out = pcmsk2_q;
        dm_out_en   = 1'b1;
      end
    end
  end

  assign INT0_EN = eimsk_q[0];
  assign INT1_EN = eimsk_q[1];
  assign PCIE2   = pcicr_q;
  assign PCINT   = pcmsk2_q;

  // Level mode requests straight from the synchronized pin, bypassing the flag.
  assign int0_irq   = eimsk_q[0] & (eifr_q[0] | ((eicra_q[1:0] == 2'b00) & ~s2_q[2]));
  assign int1_irq   = eimsk_q[1] & (eifr_q[1] | ((eicra_q[3:2] == 2'b00) & ~s2_q[3]));
  assign pcint2_irq = pcicr_q & pcif_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: register access table plus multi-cycle interrupt sequences.
module tb_ext_int_ctrl;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en;
  logic [7:0] ramadr;
  logic       ramre, ramwe;
  logic [7:0] dm_dbus_out;
  logic       dm_out_en;
  logic [7:0] pinD_i;
  logic       INT0_EN, INT1_EN, PCIE2;
  logic [7:0] PCINT;
  logic       int0_irq, int1_irq, pcint2_irq;
  logic       int0_ack, int1_ack, pcint2_ack;

  int errors = 0;
  int checks = 0;

  always #5 cp2 = ~cp2;

  ext_int_ctrl dut (
    .cp2(cp2), .ireset(ireset),
    .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dm_dbus_out(dm_dbus_out), .dm_out_en(dm_out_en),
    .pinD_i(pinD_i),
    .INT0_EN(INT0_EN), .INT1_EN(INT1_EN), .PCIE2(PCIE2), .PCINT(PCINT),
    .int0_irq(int0_irq), .int1_irq(int1_irq), .pcint2_irq(pcint2_irq),
    .int0_ack(int0_ack), .int1_ack(int1_ack), .pcint2_ack(pcint2_ack)
  );

  typedef struct {
    bit         is_io;
    bit         do_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_en;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    tick();
    iowe = 1'b0; dbus_in = 8'h00;
  endtask

  task automatic dm_wr(input logic [7:0] a, input logic [7:0] d);
    ramadr = a; dbus_in = d; ramwe = 1'b1;
    tick();
    ramwe = 1'b0; dbus_in = 8'h00;
  endtask

  task automatic io_rd(input logic [5:0] a, input logic en, input logic [7:0] d, input string name);
    IO_Addr = a; iore = 1'b1;
    #1;
    chk({name, "_en"}, {7'b0, out_en}, {7'b0, en});
    chk(name, dbus_out, d);
    iore = 1'b0;
    #1;
  endtask

  task automatic dm_rd(input logic [7:0] a, input logic en, input logic [7:0] d, input string name);
    ramadr = a; ramre = 1'b1;
    #1;
    chk({name, "_en"}, {7'b0, dm_out_en}, {7'b0, en});
    chk(name, dm_dbus_out, d);
    ramre = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    pinD_i = 8'hFF;
    ireset = 1'b1;
    tick();
    tick();
    ireset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ireset = 1'b1; IO_Addr = '0; iore = 0; iowe = 0; dbus_in = '0;
    ramadr = '0; ramre = 0; ramwe = 0; pinD_i = 8'hFF;
    int0_ack = 0; int1_ack = 0; pcint2_ack = 0;

    tbl[0]  = '{1'b1, 1'b1, 8'h1D, 8'hFF, 1'b1, 8'h03};
    tbl[1]  = '{1'b1, 1'b1, 8'h1D, 8'h00, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h69, 8'hFF, 1'b1, 8'h0F};
    tbl[3]  = '{1'b0, 1'b1, 8'h69, 8'h5A, 1'b1, 8'h0A};
    tbl[4]  = '{1'b0, 1'b1, 8'h68, 8'hFF, 1'b1, 8'h04};
    tbl[5]  = '{1'b0, 1'b1, 8'h6D, 8'hA5, 1'b1, 8'hA5};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 8'h1E, 8'hFF, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 8'h6A, 8'h00, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 8'h1C, 8'hFF, 1'b1, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 8'h1B, 8'hFF, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 8'h1D, 8'h00, 1'b0, 8'h00};

    do_reset();

    // Reset state
    io_rd(6'h1D, 1'b1, 8'h00, "rst_eimsk");
    io_rd(6'h1C, 1'b1, 8'h00, "rst_eifr");
    io_rd(6'h1B, 1'b1, 8'h00, "rst_pcifr");
    dm_rd(8'h69, 1'b1, 8'h00, "rst_eicra");
    dm_rd(8'h6D, 1'b1, 8'h00, "rst_pcmsk2");
    chk("rst_irqs", {5'b0, int0_irq, int1_irq, pcint2_irq}, 8'h00);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_io) begin
        if (tbl[i].do_wr) io_wr(tbl[i].addr[5:0], tbl[i].wdata);
        io_rd(tbl[i].addr[5:0], tbl[i].exp_en, tbl[i].exp_rd, $sformatf("tbl%0d", i));
      end else begin
        if (tbl[i].do_wr) dm_wr(tbl[i].addr, tbl[i].wdata);
        dm_rd(tbl[i].addr, tbl[i].exp_en, tbl[i].exp_rd, $sformatf("tbl%0d", i));
      end
    end
    chk("pcint_port", PCINT, 8'hA5);
    chk("pcie2_port", {7'b0, PCIE2}, 8'h01);

    // INT0 falling edge, latency and ack clear
    do_reset();
    dm_wr(8'h69, 8'h02);
    io_wr(6'h1D, 8'h01);
    pinD_i = 8'hFB;
    tick();
    io_rd(6'h1C, 1'b1, 8'h00, "int0_k");
    tick();
    io_rd(6'h1C, 1'b1, 8'h00, "int0_k1");
    tick();
    io_rd(6'h1C, 1'b1, 8'h01, "int0_k2");
    chk("int0_irq_set", {7'b0, int0_irq}, 8'h01);
    int0_ack = 1'b1;
    tick();
    int0_ack = 1'b0;
    io_rd(6'h1C, 1'b1, 8'h00, "int0_ack_clr");
    chk("int0_irq_ack", {7'b0, int0_irq}, 8'h00);

    // INT1 low level
    do_reset();
    io_wr(6'h1D, 8'h02);
    pinD_i = 8'hF7;
    tick();
    chk("int1_lvl_k", {7'b0, int1_irq}, 8'h00);
    tick();
    chk("int1_lvl_k1", {7'b0, int1_irq}, 8'h01);
    io_rd(6'h1C, 1'b1, 8'h00, "int1_lvl_noflag");
    pinD_i = 8'hFF;
    tick();
    chk("int1_lvl_hold", {7'b0, int1_irq}, 8'h01);
    tick();
    chk("int1_lvl_drop", {7'b0, int1_irq}, 8'h00);

    // Pin change group 2, masked then enabled, then write-1 clear
    do_reset();
    dm_wr(8'h6D, 8'h81);
    pinD_i = 8'h7F;
    tick();
    tick();
    io_rd(6'h1B, 1'b1, 8'h00, "pc_k1");
    tick();
    io_rd(6'h1B, 1'b1, 8'h04, "pc_k2");
    chk("pc_irq_masked", {7'b0, pcint2_irq}, 8'h00);
    dm_wr(8'h68, 8'h04);
    chk("pc_irq_en", {7'b0, pcint2_irq}, 8'h01);
    io_wr(6'h1B, 8'h04);
    io_rd(6'h1B, 1'b1, 8'h00, "pc_w1c");
    chk("pc_irq_clr", {7'b0, pcint2_irq}, 8'h00);

    // Set beats a coincident write-1 clear; writing 0 has no effect
    do_reset();
    dm_wr(8'h69, 8'h03);
    io_wr(6'h1D, 8'h01);
    pinD_i = 8'hFB;
    tick(); tick(); tick();
    io_rd(6'h1C, 1'b1, 8'h00, "rise_ignores_fall");
    pinD_i = 8'hFF;
    tick();
    tick();
    io_wr(6'h1C, 8'h01);
    io_rd(6'h1C, 1'b1, 8'h01, "set_wins");
    io_wr(6'h1C, 8'h00);
    io_rd(6'h1C, 1'b1, 8'h01, "wr0_noeffect");
    io_wr(6'h1C, 8'h01);
    io_rd(6'h1C, 1'b1, 8'h00, "wr1_clear");

    // Reset overrides a coincident write
    IO_Addr = 6'h1D; dbus_in = 8'hFF; iowe = 1'b1; ireset = 1'b1;
    tick();
    iowe = 1'b0; ireset = 1'b0;
    io_rd(6'h1D, 1'b1, 8'h00, "rst_over_wr");

    // No flags from pins changing around reset release
    pinD_i = 8'hFF;
    ireset = 1'b1;
    tick(); tick();
    ireset = 1'b0;
    dm_wr(8'h69, 8'h0F);
    pinD_i = 8'h00;
    tick(); tick(); tick(); tick();
    io_rd(6'h1C, 1'b1, 8'h00, "post_rst_eifr");
    io_rd(6'h1B, 1'b1, 8'h00, "post_rst_pcifr");

    // Unmapped and unselected reads
    io_rd(6'h00, 1'b0, 8'h00, "unmap_io00");
    io_rd(6'h3F, 1'b0, 8'h00, "unmap_io3f");
    dm_rd(8'h6B, 1'b0, 8'h00, "unmap_dm6b");
    IO_Addr = 6'h1D; iore = 1'b0;
    #1;
    chk("no_iore_en", {7'b0, out_en}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
